// File: rtl/scr_stack_ctrl_if.sv
// Interface bundling the control-unit operation bus and the scratch-RAM outputs
// of scr_stack_ctrl.
//   master : control-unit side (drives op/addresses/data/flag_clr, observes RAM and stack outputs)
//   slave  : scr_stack_ctrl side
// Signals:
//   op_valid, op[3:0], reg_addr, imm_addr, reg_data, pc_data, flag_clr  -> stage
//   scr_addr, scr_we, scr_data_in                                       -> scratch RAM
//   sp_out, stk_ovf, stk_unf                                            -> status
interface scr_stack_ctrl_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 8
);
    logic              op_valid;
    logic [3:0]        op;
    logic [ADDR_W-1:0] reg_addr;
    logic [ADDR_W-1:0] imm_addr;
    logic [DATA_W-1:0] reg_data;
    logic [DATA_W-1:0] pc_data;
    logic              flag_clr;
    logic [ADDR_W-1:0] scr_addr;
    logic              scr_we;
    logic [DATA_W-1:0] scr_data_in;
    logic [ADDR_W-1:0] sp_out;
    logic              stk_ovf;
    logic              stk_unf;

    modport master (
        output op_valid, op, reg_addr, imm_addr, reg_data, pc_data, flag_clr,
        input  scr_addr, scr_we, scr_data_in, sp_out, stk_ovf, stk_unf
    );

    modport slave (
        input  op_valid, op, reg_addr, imm_addr, reg_data, pc_data, flag_clr,
        output scr_addr, scr_we, scr_data_in, sp_out, stk_ovf, stk_unf
    );
endinterface

// File: rtl/scr_stack_ctrl.sv
// scr_stack_ctrl: scratch-RAM access and stack-pointer stage.
// Decodes one operation per cycle into scratch-RAM address/write-enable/write-data
// (combinational, the RAM samples on the same edge) and owns the stack pointer.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : scr_stack_ctrl_if.slave (operation inputs, RAM outputs, SP and sticky flags)
// Configuration:
//   SCR_STACK_GUARD_EN defined   -> depth counter blocks push-on-full / pop-on-empty and
//                                   raises sticky stk_ovf / stk_unf (cleared by flag_clr, set wins).
//   SCR_STACK_GUARD_EN undefined -> SP wraps freely, flags tied low, flag_clr ignored.
module scr_stack_ctrl #(
    parameter int DATA_W   = 10,
    parameter int ADDR_W   = 8,
    parameter int SP_RESET = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    scr_stack_ctrl_if.slave bus
);
    localparam logic [3:0] OP_LD_R = 4'd1;
    localparam logic [3:0] OP_LD_I = 4'd2;
    localparam logic [3:0] OP_ST_R = 4'd3;
    localparam logic [3:0] OP_ST_I = 4'd4;
    localparam logic [3:0] OP_PUSH = 4'd5;
    localparam logic [3:0] OP_POP  = 4'd6;
    localparam logic [3:0] OP_CALL = 4'd7;
    localparam logic [3:0] OP_RET  = 4'd8;
    localparam logic [3:0] OP_WSP  = 4'd9;

    logic [ADDR_W-1:0] sp;
    logic [ADDR_W-1:0] sp_nxt;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] data_c;
    logic              we_c;
    logic              push_op;
    logic              pop_op;
    logic              wsp_op;
    logic              push_blk;
    logic              pop_blk;

    always_comb begin
        addr_c  = bus.reg_addr;
        data_c  = bus.reg_data;
        we_c    = 1'b0;
        sp_nxt  = sp;
        push_op = 1'b0;
        pop_op  = 1'b0;
        wsp_op  = 1'b0;
        if (bus.op_valid) begin
            case (bus.op)
                OP_LD_R: addr_c = bus.reg_addr;
                OP_LD_I: addr_c = bus.imm_addr;
                OP_ST_R: we_c = 1'b1;
                OP_ST_I: begin
                    addr_c = bus.imm_addr;
                    we_c   = 1'b1;
                end
                OP_PUSH, OP_CALL: begin
                    push_op = 1'b1;
                    addr_c  = sp - ADDR_W'(1);
                    we_c    = ~push_blk;
                    if (bus.op == OP_CALL) data_c = bus.pc_data;
                    if (!push_blk) sp_nxt = sp - ADDR_W'(1);
                end
                OP_POP, OP_RET: begin
                    // RAM is read asynchronously at the current top of stack
                    pop_op = 1'b1;
                    addr_c = sp;
                    if (!pop_blk) sp_nxt = sp + ADDR_W'(1);
                end
                OP_WSP: begin
                    wsp_op = 1'b1;
                    sp_nxt = bus.reg_data[ADDR_W-1:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sp <= ADDR_W'(SP_RESET);
        else        sp <= sp_nxt;
    end

`ifdef SCR_STACK_GUARD_EN
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0] count;
    logic            ovf;
    logic            unf;

    assign push_blk = (count == FULL);
    assign pop_blk  = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (wsp_op)                   count <= '0;
            else if (push_op && !push_blk) count <= count + 1'b1;
            else if (pop_op && !pop_blk)   count <= count - 1'b1;
            // a new error in the same cycle as flag_clr keeps the flag set
            ovf <= (ovf & ~bus.flag_clr) | (push_op & push_blk);
            unf <= (unf & ~bus.flag_clr) | (pop_op & pop_blk);
        end
    end

    assign bus.stk_ovf = ovf;
    assign bus.stk_unf = unf;
`else
    assign push_blk    = 1'b0;
    assign pop_blk     = 1'b0;
    assign bus.stk_ovf = 1'b0;
    assign bus.stk_unf = 1'b0;
    wire   unused_ok   = &{1'b0, bus.flag_clr, push_op, pop_op, wsp_op};
`endif

    // write enable is gated by reset so a write cannot land while reset is asserted
    assign bus.scr_addr    = addr_c;
    assign bus.scr_we      = we_c & rst_n;
    assign bus.scr_data_in = data_c;
    assign bus.sp_out      = sp;
endmodule

// File: tb/tb_scr_stack_ctrl.sv
// Self-checking bench for scr_stack_ctrl: directed scenarios plus a randomized run
// against a stack model written with modular arithmetic. Works with or without
// SCR_STACK_GUARD_EN defined.
module tb_scr_stack_ctrl;
    localparam int DW = 10;
    localparam int AW = 8;
    localparam int DEPTH = 256;
    localparam logic [3:0] NOP = 4'd0, LD_R = 4'd1, LD_I = 4'd2, ST_R = 4'd3, ST_I = 4'd4;
    localparam logic [3:0] PUSH = 4'd5, POP = 4'd6, CALL = 4'd7, RET = 4'd8, WSP = 4'd9;
`ifdef SCR_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    scr_stack_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    scr_stack_ctrl #(.DATA_W(DW), .ADDR_W(AW), .SP_RESET(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    int n_checks = 0;
    int n_fail = 0;

    // reference model
    int m_sp, m_cnt;
    bit m_ovf, m_unf;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_we;
    bit cur_v, cur_fc;
    logic [3:0] cur_op;
    logic [DW-1:0] cur_rd;

    task automatic model_reset();
        m_sp = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic drive(input bit v, input logic [3:0] op, input logic [AW-1:0] ra,
                         input logic [AW-1:0] ia, input logic [DW-1:0] rd,
                         input logic [DW-1:0] pc, input bit fc);
        @(negedge clk);
        bus.op_valid = v; bus.op = op; bus.reg_addr = ra; bus.imm_addr = ia;
        bus.reg_data = rd; bus.pc_data = pc; bus.flag_clr = fc;
        cur_v = v; cur_op = op; cur_rd = rd; cur_fc = fc;
        e_addr = ra; e_we = 1'b0; e_data = rd;
        if (v) begin
            case (op)
                LD_I: e_addr = ia;
                ST_R: e_we = 1'b1;
                ST_I: begin e_addr = ia; e_we = 1'b1; end
                PUSH, CALL: begin
                    e_addr = AW'((m_sp + DEPTH - 1) % DEPTH);
                    e_we   = !(GUARD && m_cnt == DEPTH);
                    if (op == CALL) e_data = pc;
                end
                POP, RET: e_addr = AW'(m_sp);
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (GUARD && cur_fc) begin m_ovf = 0; m_unf = 0; end
        if (cur_v) begin
            case (cur_op)
                PUSH, CALL: if (GUARD && m_cnt == DEPTH) m_ovf = 1;
                            else begin m_sp = (m_sp + DEPTH - 1) % DEPTH; m_cnt++; end
                POP, RET:   if (GUARD && m_cnt == 0) m_unf = 1;
                            else begin m_sp = (m_sp + 1) % DEPTH; m_cnt--; end
                WSP:        begin m_sp = int'(cur_rd) % DEPTH; m_cnt = 0; end
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.op_valid = 0; bus.op = NOP; bus.reg_addr = 0; bus.imm_addr = 0;
        bus.reg_data = 0; bus.pc_data = 0; bus.flag_clr = 0;
        cur_v = 0; cur_op = NOP; cur_rd = 0; cur_fc = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        #12;
        n_checks++; if (bus.scr_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b need 0", bus.scr_we); end
        n_checks++; if (bus.sp_out !== 8'h00) begin n_fail++; $display("FAIL reset_sp: got %h need 00", bus.sp_out); end
        n_checks++; if ({bus.stk_ovf, bus.stk_unf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b need 00", {bus.stk_ovf, bus.stk_unf}); end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_push();
        drive(1, PUSH, 8'h00, 8'h00, 10'h2A5, 10'h000, 0);
        n_checks++; if (bus.scr_addr !== 8'hFF) begin n_fail++; $display("FAIL push_addr: got %h need ff", bus.scr_addr); end
        n_checks++; if (bus.scr_we !== 1'b1) begin n_fail++; $display("FAIL push_we: got %b need 1", bus.scr_we); end
        n_checks++; if (bus.scr_data_in !== 10'h2A5) begin n_fail++; $display("FAIL push_data: got %h need 2a5", bus.scr_data_in); end
        tick();
        n_checks++; if (bus.sp_out !== 8'hFF) begin n_fail++; $display("FAIL push_sp: got %h need ff", bus.sp_out); end
    endtask

    task automatic test_call_ret();
        drive(1, CALL, 8'h11, 8'h22, 10'h0AA, 10'h123, 0);
        n_checks++; if ({bus.scr_addr, bus.scr_we, bus.scr_data_in} !== {8'hFE, 1'b1, 10'h123})
            begin n_fail++; $display("FAIL call_write: got %h/%b/%h need fe/1/123", bus.scr_addr, bus.scr_we, bus.scr_data_in); end
        tick();
        n_checks++; if (bus.sp_out !== 8'hFE) begin n_fail++; $display("FAIL call_sp: got %h need fe", bus.sp_out); end
        drive(1, RET, 8'h11, 8'h22, 10'h0AA, 10'h000, 0);
        n_checks++; if ({bus.scr_addr, bus.scr_we} !== {8'hFE, 1'b0})
            begin n_fail++; $display("FAIL ret_read: got %h/%b need fe/0", bus.scr_addr, bus.scr_we); end
        tick();
        n_checks++; if (bus.sp_out !== 8'hFF) begin n_fail++; $display("FAIL ret_sp: got %h need ff", bus.sp_out); end
    endtask

    task automatic test_store_load();
        drive(1, ST_I, 8'h05, 8'h40, 10'h3FF, 10'h000, 0);
        n_checks++; if ({bus.scr_addr, bus.scr_we, bus.scr_data_in} !== {8'h40, 1'b1, 10'h3FF})
            begin n_fail++; $display("FAIL st_i: got %h/%b/%h need 40/1/3ff", bus.scr_addr, bus.scr_we, bus.scr_data_in); end
        tick();
        drive(1, LD_R, 8'h40, 8'h07, 10'h001, 10'h000, 0);
        n_checks++; if ({bus.scr_addr, bus.scr_we} !== {8'h40, 1'b0})
            begin n_fail++; $display("FAIL ld_r: got %h/%b need 40/0", bus.scr_addr, bus.scr_we); end
        tick();
        n_checks++; if (bus.sp_out !== 8'hFF) begin n_fail++; $display("FAIL ldst_sp: got %h need ff", bus.sp_out); end
        drive(1, ST_R, 8'h3C, 8'h07, 10'h155, 10'h000, 0);
        n_checks++; if ({bus.scr_addr, bus.scr_we, bus.scr_data_in} !== {8'h3C, 1'b1, 10'h155})
            begin n_fail++; $display("FAIL st_r: got %h/%b/%h need 3c/1/155", bus.scr_addr, bus.scr_we, bus.scr_data_in); end
        tick();
        drive(1, LD_I, 8'h3C, 8'h9A, 10'h155, 10'h000, 0);
        n_checks++; if ({bus.scr_addr, bus.scr_we} !== {8'h9A, 1'b0})
            begin n_fail++; $display("FAIL ld_i: got %h/%b need 9a/0", bus.scr_addr, bus.scr_we); end
        tick();
        drive(0, PUSH, 8'h33, 8'h44, 10'h2C1, 10'h0F0, 0);
        n_checks++; if ({bus.scr_addr, bus.scr_we, bus.scr_data_in} !== {8'h33, 1'b0, 10'h2C1})
            begin n_fail++; $display("FAIL idle_out: got %h/%b/%h need 33/0/2c1", bus.scr_addr, bus.scr_we, bus.scr_data_in); end
        tick();
        n_checks++; if (bus.sp_out !== 8'hFF) begin n_fail++; $display("FAIL idle_sp: got %h need ff", bus.sp_out); end
    endtask

    task automatic test_wsp_pop();
        drive(1, WSP, 8'h00, 8'h00, 10'h010, 10'h000, 0);
        n_checks++; if (bus.scr_we !== 1'b0) begin n_fail++; $display("FAIL wsp_we: got %b need 0", bus.scr_we); end
        tick();
        n_checks++; if (bus.sp_out !== 8'h10) begin n_fail++; $display("FAIL wsp_sp: got %h need 10", bus.sp_out); end
        drive(1, POP, 8'h00, 8'h00, 10'h000, 10'h000, 0);
        n_checks++; if ({bus.scr_addr, bus.scr_we} !== {8'h10, 1'b0})
            begin n_fail++; $display("FAIL pop_read: got %h/%b need 10/0", bus.scr_addr, bus.scr_we); end
        tick();
        n_checks++; if (bus.sp_out !== (GUARD ? 8'h10 : 8'h11)) begin n_fail++; $display("FAIL pop_sp: got %h need %h", bus.sp_out, GUARD ? 8'h10 : 8'h11); end
        n_checks++; if (bus.stk_unf !== GUARD) begin n_fail++; $display("FAIL pop_unf: got %b need %b", bus.stk_unf, GUARD); end
        drive(0, NOP, 8'h00, 8'h00, 10'h000, 10'h000, 1);
        tick();
        n_checks++; if (bus.stk_unf !== 1'b0) begin n_fail++; $display("FAIL unf_clr: got %b need 0", bus.stk_unf); end
    endtask

    task automatic test_overflow();
        pulse_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, (i % 2) ? CALL : PUSH, 8'h00, 8'h00, DW'($urandom), DW'($urandom), 0);
            n_checks++; if ({bus.scr_addr, bus.scr_we, bus.scr_data_in} !== {e_addr, 1'b1, e_data})
                begin n_fail++; $display("FAIL fill_%0d: got %h/%b/%h need %h/1/%h", i, bus.scr_addr, bus.scr_we, bus.scr_data_in, e_addr, e_data); end
            tick();
        end
        n_checks++; if (bus.sp_out !== 8'h00) begin n_fail++; $display("FAIL full_sp: got %h need 00", bus.sp_out); end
        drive(1, PUSH, 8'h00, 8'h00, 10'h1F0, 10'h000, 0);
        n_checks++; if (bus.scr_we !== !GUARD) begin n_fail++; $display("FAIL ovf_we: got %b need %b", bus.scr_we, !GUARD); end
        tick();
        n_checks++; if (bus.sp_out !== (GUARD ? 8'h00 : 8'hFF)) begin n_fail++; $display("FAIL ovf_sp: got %h need %h", bus.sp_out, GUARD ? 8'h00 : 8'hFF); end
        n_checks++; if (bus.stk_ovf !== GUARD) begin n_fail++; $display("FAIL ovf_flag: got %b need %b", bus.stk_ovf, GUARD); end
        drive(0, NOP, 8'h00, 8'h00, 10'h000, 10'h000, 1);
        tick();
        n_checks++; if (bus.stk_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b need 0", bus.stk_ovf); end
        // error in the same cycle as flag_clr: the flag must end up set
        drive(1, PUSH, 8'h00, 8'h00, 10'h0F0, 10'h000, 1);
        tick();
        n_checks++; if (bus.stk_ovf !== GUARD) begin n_fail++; $display("FAIL ovf_set_wins: got %b need %b", bus.stk_ovf, GUARD); end
        n_checks++; if (bus.sp_out !== AW'(m_sp)) begin n_fail++; $display("FAIL ovf2_sp: got %h need %h", bus.sp_out, AW'(m_sp)); end
        pulse_reset();
        drive(1, RET, 8'h00, 8'h00, 10'h000, 10'h000, 0);
        tick();
        n_checks++; if ({bus.sp_out, bus.stk_unf} !== {(GUARD ? 8'h00 : 8'h01), GUARD})
            begin n_fail++; $display("FAIL empty_ret: got %h/%b need %h/%b", bus.sp_out, bus.stk_unf, GUARD ? 8'h00 : 8'h01, GUARD); end
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int i = 0; i < 400; i++) begin
            // bias towards stack ops so the depth wanders
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(5, 8));
            if ($urandom_range(0, 40) == 0) op = WSP;
            drive($urandom_range(0, 9) != 0, op, AW'($urandom), AW'($urandom), DW'($urandom),
                  DW'($urandom), $urandom_range(0, 19) == 0);
            n_checks++; if ({bus.scr_addr, bus.scr_we} !== {e_addr, e_we})
                begin n_fail++; $display("FAIL rnd_addr_we[%0d]: got %h/%b need %h/%b", i, bus.scr_addr, bus.scr_we, e_addr, e_we); end
            if (e_we) begin
                n_checks++; if (bus.scr_data_in !== e_data)
                    begin n_fail++; $display("FAIL rnd_data[%0d]: got %h need %h", i, bus.scr_data_in, e_data); end
            end
            tick();
            n_checks++; if ({bus.sp_out, bus.stk_ovf, bus.stk_unf} !== {AW'(m_sp), m_ovf, m_unf})
                begin n_fail++; $display("FAIL rnd_state[%0d]: got %h/%b/%b need %h/%b/%b", i, bus.sp_out, bus.stk_ovf, bus.stk_unf, AW'(m_sp), m_ovf, m_unf); end
        end
    endtask

    task automatic test_async_reset();
        pulse_reset();
        drive(1, PUSH, 8'h00, 8'h00, 10'h2A5, 10'h000, 0);
        tick();
        drive(1, PUSH, 8'h00, 8'h00, 10'h15A, 10'h000, 0);
        n_checks++; if (bus.scr_we !== 1'b1) begin n_fail++; $display("FAIL midop_we_before: got %b need 1", bus.scr_we); end
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_checks++; if (bus.scr_we !== 1'b0) begin n_fail++; $display("FAIL midop_we: got %b need 0", bus.scr_we); end
        n_checks++; if (bus.sp_out !== 8'h00) begin n_fail++; $display("FAIL midop_sp: got %h need 00", bus.sp_out); end
        n_checks++; if ({bus.stk_ovf, bus.stk_unf} !== 2'b00) begin n_fail++; $display("FAIL midop_flags: got %b need 00", {bus.stk_ovf, bus.stk_unf}); end
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        drive(1, PUSH, 8'h00, 8'h00, 10'h001, 10'h000, 0);
        n_checks++; if (bus.scr_addr !== 8'hFF) begin n_fail++; $display("FAIL post_reset_addr: got %h need ff", bus.scr_addr); end
        tick();
    endtask

    initial begin
        test_reset();
        test_push();
        test_call_ret();
        test_store_load();
        test_wsp_pop();
        test_overflow();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
